// File: rtl/sobel_edge_detector.sv
// Sobel gradient-magnitude stage: streams a blurred luma frame from memory in
// fixed 8-cycle slots and writes back {edge, magnitude} as a YCrCb word.
module sobel_edge_detector #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter logic [9:0]  THRESHOLD = 10'd128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [18:0] read_addr,
  input  logic [35:0] read_data,
  output logic [18:0] write_addr,
  output logic [35:0] write_data,
  output logic        write_enable
);
  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  PRIME  = 2'd1;
  localparam logic [1:0]  PIXEL  = 2'd2;
  localparam logic [1:0]  FINISH = 2'd3;
  localparam logic [9:0]  X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
  localparam logic [10:0] N_COLS = 11'(WIDTH);

  logic [1:0]  r_state;
  logic [2:0]  r_sc;
  logic [9:0]  r_x;
  logic [8:0]  r_y;
  logic [9:0]  r_win [3][3];  // [column c0..c2][row y-1..y+1]
  logic [9:0]  r_cap0, r_cap1, r_cap2;
  logic [18:0] r_hold_addr;
  logic        r_we;
  logic [18:0] r_waddr;
  logic [35:0] r_wdata;

  logic        w_active, w_col_ok, w_issue, w_border, w_edge;
  logic [10:0] w_col;
  logic [8:0]  w_tap_row;
  logic [1:0]  w_cap_sel;
  logic [9:0]  w_cap, w_mag;
  logic [12:0] w_left, w_right, w_top, w_bot, w_gx, w_gy, w_ax, w_ay, w_sum;

  // Row k of the slot is y-1+k; rows above and below the frame are absent.
  function automatic logic row_ok(input logic [1:0] k, input logic [8:0] y);
    return (k == 2'd0) ? (y != 9'd0) : (k == 2'd2) ? (y != Y_LAST) : 1'b1;
  endfunction

  assign w_active  = (r_state == PRIME) || (r_state == PIXEL);
  assign w_col     = (r_state == PRIME) ? 11'd0 : {1'b0, r_x} + 11'd1;
  assign w_col_ok  = w_col < N_COLS;
  assign w_tap_row = r_y + {7'd0, r_sc[1:0]} - 9'd1;
  assign w_issue   = w_active && (r_sc < 3'd3) && w_col_ok && row_ok(r_sc[1:0], r_y);
  assign read_addr = w_issue ? {w_tap_row, w_col[9:0]} : r_hold_addr;

  // Data arrives two cycles after issue, so s2..s4 capture rows 0..2.
  assign w_cap_sel = r_sc[1:0] - 2'd2;
  assign w_cap     = (w_col_ok && row_ok(w_cap_sel, r_y)) ? read_data[29:20] : '0;

  assign w_left  = {3'b0, r_win[0][0]} + {2'b0, r_win[0][1], 1'b0} + {3'b0, r_win[0][2]};
  assign w_right = {3'b0, r_win[2][0]} + {2'b0, r_win[2][1], 1'b0} + {3'b0, r_win[2][2]};
  assign w_top   = {3'b0, r_win[0][0]} + {2'b0, r_win[1][0], 1'b0} + {3'b0, r_win[2][0]};
  assign w_bot   = {3'b0, r_win[0][2]} + {2'b0, r_win[1][2], 1'b0} + {3'b0, r_win[2][2]};
  assign w_gx    = w_right - w_left;
  assign w_gy    = w_bot - w_top;
  assign w_ax    = w_gx[12] ? -w_gx : w_gx;
  assign w_ay    = w_gy[12] ? -w_gy : w_gy;
  assign w_sum   = w_ax + w_ay;
  assign w_border = (r_x == 10'd0) || (r_x == X_LAST) || (r_y == 9'd0) || (r_y == Y_LAST);
  assign w_mag   = w_border ? '0 : w_sum[12:3];
  assign w_edge  = !w_border && (w_mag >= THRESHOLD);

  assign done         = (r_state == FINISH) && !start;
  assign write_enable = r_we;
  assign write_addr   = r_waddr;
  assign write_data   = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_sc        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_cap0      <= '0;
      r_cap1      <= '0;
      r_cap2      <= '0;
      r_hold_addr <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      for (int unsigned i = 0; i < 3; i++)
        for (int unsigned j = 0; j < 3; j++) r_win[i][j] <= '0;
    end else begin
      r_we        <= 1'b0;
      r_hold_addr <= read_addr;
      if (start) begin
        r_state <= PRIME;
        r_sc    <= '0;
        r_x     <= '0;
        r_y     <= '0;
        for (int unsigned i = 0; i < 3; i++)
          for (int unsigned j = 0; j < 3; j++) r_win[i][j] <= '0;
      end else if (r_state == FINISH) begin
        r_state <= IDLE;
      end else if (w_active) begin
        r_sc <= r_sc + 3'd1;
        case (r_sc)
          3'd2: r_cap0 <= w_cap;
          3'd3: r_cap1 <= w_cap;
          3'd4: r_cap2 <= w_cap;
          3'd5: begin
            for (int unsigned j = 0; j < 3; j++) begin
              r_win[0][j] <= r_win[1][j];
              r_win[1][j] <= r_win[2][j];
            end
            r_win[2][0] <= r_cap0;
            r_win[2][1] <= r_cap1;
            r_win[2][2] <= r_cap2;
          end
          3'd6: if (r_state == PIXEL) begin
            r_we    <= 1'b1;
            r_waddr <= {r_y, r_x};
            r_wdata <= {5'b0, w_edge, w_mag, 10'd512, 10'd512};
          end
          3'd7: begin
            if (r_state == PRIME) begin
              r_state <= PIXEL;
            end else if (r_x != X_LAST) begin
              r_x <= r_x + 10'd1;
            end else if (r_y == Y_LAST) begin
              r_state <= FINISH;
            end else begin
              r_x     <= '0;
              r_y     <= r_y + 9'd1;
              r_state <= PRIME;
              for (int unsigned i = 0; i < 3; i++)
                for (int unsigned j = 0; j < 3; j++) r_win[i][j] <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_detector.sv
// Directed bench for sobel_edge_detector on an 8x4 frame with a 2-cycle-latency memory model.
module tb_sobel_edge_detector;
  localparam int W = 8;
  localparam int H = 4;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        done, write_enable;
  logic [18:0] read_addr, write_addr;
  logic [35:0] read_data, write_data, rd1;

  int n_asrt = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  int wr_cnt = 0, done_cnt = 0, done_cyc = 0, order_err = 0, low_err = 0;
  int saved_wr, bad;
  logic [9:0]  img [H][W];
  logic [35:0] got [H][W];

  sobel_edge_detector #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(10'd128)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .read_addr(read_addr), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] mem_word(logic [18:0] a);
    int yy, xx;
    yy = int'(a[18:10]);
    xx = int'(a[9:0]);
    if (yy < H && xx < W) return {6'h2A, img[yy][xx], 20'h5A5A5};
    return {6'h15, 10'd777, 20'hFFFFF};
  endfunction

  always @(posedge clk) begin
    rd1       <= mem_word(read_addr);
    read_data <= rd1;
  end

  always @(negedge clk) begin
    if (write_enable) begin
      if (write_addr !== {9'(wr_cnt / W), 10'(wr_cnt % W)}) order_err++;
      if (write_data[19:0] !== 20'h80200 || write_data[35:31] !== 5'b0) low_err++;
      if (int'(write_addr[18:10]) < H && int'(write_addr[9:0]) < W)
        got[write_addr[18:10]][write_addr[9:0]] = write_data;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [35:0] model(int x, int y);
    int gx, gy, m;
    if (x == 0 || y == 0 || x == W - 1 || y == H - 1) return {16'h0, 20'h80200};
    gx = int'(img[y-1][x+1]) + 2 * int'(img[y][x+1]) + int'(img[y+1][x+1])
       - int'(img[y-1][x-1]) - 2 * int'(img[y][x-1]) - int'(img[y+1][x-1]);
    gy = int'(img[y+1][x-1]) + 2 * int'(img[y+1][x]) + int'(img[y+1][x+1])
       - int'(img[y-1][x-1]) - 2 * int'(img[y-1][x]) - int'(img[y-1][x+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) / 8;
    return {5'b0, m >= 128, 10'(m), 20'h80200};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_img(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0: img[y][x] = 10'd300;
          1: img[y][x] = (x < 4) ? 10'd0 : 10'd1000;
          2: img[y][x] = (y < 2) ? 10'd0 : 10'd1023;
          default: img[y][x] = (x == 3 && y == 2) ? 10'd1023 : 10'd0;
        endcase
  endtask

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; order_err = 0; low_err = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) got[y][x] = 'x;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_writes"}, 64'(wr_cnt), 64'(W * H));
    chk({tag, "_order"}, 64'(order_err), 64'd0);
    chk({tag, "_lowbits"}, 64'(low_err), 64'd0);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_latency"}, 64'(done_cyc - start_cyc + 1), 64'd290);
    bad = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (got[y][x] !== model(x, y)) bad++;
    chk({tag, "_pixels"}, 64'(bad), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_done_we", {62'd0, done, write_enable}, 64'd0);
    chk("rst_raddr", 64'(read_addr), 64'd0);
    chk("rst_waddr", 64'(write_addr), 64'd0);
    chk("rst_wdata", 64'(write_data), 64'd0);
    @(negedge clk); reset = 1'b1;

    set_img(0); clear_mon(); pulse_start(); wait_done();
    check_frame("uniform");
    chk("uniform_mid", 64'(got[2][3][30:20]), 64'd0);

    set_img(1); clear_mon(); pulse_start(); wait_done();
    check_frame("vstep");
    chk("vstep_x3", 64'(got[1][3][30:20]), 64'({1'b1, 10'd500}));
    chk("vstep_x4", 64'(got[2][4][30:20]), 64'({1'b1, 10'd500}));
    chk("vstep_x2", 64'(got[1][2][30:20]), 64'd0);
    chk("vstep_border", 64'(got[0][3][30:20]), 64'd0);

    set_img(2); clear_mon(); pulse_start(); wait_done();
    check_frame("hstep");
    chk("hstep_y1", 64'(got[1][2][30:20]), 64'({1'b1, 10'd511}));
    chk("hstep_y2", 64'(got[2][5][30:20]), 64'({1'b1, 10'd511}));
    chk("hstep_border", 64'(got[3][4][30:20]), 64'd0);

    set_img(3); clear_mon(); pulse_start(); wait_done();
    check_frame("hot");
    chk("hot_2_1", 64'(got[1][2][30:20]), 64'({1'b1, 10'd255}));
    chk("hot_3_1", 64'(got[1][3][30:20]), 64'({1'b1, 10'd255}));
    chk("hot_3_2", 64'(got[2][3][30:20]), 64'd0);

    // Reset asserted in frame cycle 100 (start cycle counted as 1).
    clear_mon(); pulse_start();
    repeat (98) @(posedge clk);
    #1 saved_wr = wr_cnt; reset = 1'b0;
    #1;
    chk("midrst_pre_writes", 64'(saved_wr), 64'd10);
    chk("midrst_done_we", {62'd0, done, write_enable}, 64'd0);
    chk("midrst_raddr", 64'(read_addr), 64'd0);
    chk("midrst_waddr", 64'(write_addr), 64'd0);
    chk("midrst_wdata", 64'(write_data), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (300) @(posedge clk);
    chk("midrst_no_writes", 64'(wr_cnt), 64'd10);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    clear_mon(); pulse_start(); wait_done();
    check_frame("after_rst");

    // Second start in frame cycle 150.
    set_img(1); clear_mon(); pulse_start();
    repeat (147) @(posedge clk);
    chk("restart_pre_done", 64'(done_cnt), 64'd0);
    clear_mon(); pulse_start(); wait_done();
    check_frame("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_edge_detector.md
# sobel_edge_detector

- Frame-processing stage that sits directly downstream of the Gaussian blur pass in the Rectilinearizer pipeline.
- Reads the blurred grayscale frame from frame memory and computes a 3×3 Sobel gradient magnitude per pixel.
- Writes the 10-bit magnitude, plus a thresholded edge flag, back as a YCrCb word for the corner/line-finding stages.
- Runs one frame per `start` pulse and signals completion with a one-cycle `done`.

## Interface
- `WIDTH`, 640, pixels per line.
- `HEIGHT`, 480, lines per frame.
- `THRESHOLD`, 10'd128, edge-flag threshold on the scaled magnitude.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: one-cycle pulse, begins or restarts a frame.
- `done` output 1: one-cycle pulse after the last write of a frame.
- `read_addr` output 19: frame-memory read address `{y[8:0], x[9:0]}`.
- `read_data` input 36: word for the address presented 2 cycles earlier; luma in [29:20].
- `write_addr` output 19: result address `{y, x}`.
- `write_data` output 36: `{5'b0, edge, mag[9:0], 10'd512, 10'd512}`.
- `write_enable` output 1: one-cycle strobe per output pixel.

## Operation
- States:
  - IDLE: wait for `start`.
  - PRIME: start-of-row column load.
  - PIXEL: 8-cycle slot per pixel.
  - FINISH: assert `done`, return to IDLE.
- Window: 3×3 array of 10-bit luma, organised as columns c0, c1, c2, each holding rows y-1, y, y+1.
- Row start: window cleared to 0, then a PRIME slot loads column 0 into c2. No write is issued.
- PIXEL slot for pixel (x,y) loads column x+1. After the shift, c0 = x-1, c1 = x, c2 = x+1.
- Slot cycles (identical for PRIME and PIXEL):
  - s0: issue addr for row y-1.
  - s1: issue addr for row y.
  - s2: issue addr for row y+1; capture row y-1 data.
  - s3: capture row y.
  - s4: capture row y+1.
  - s5: shift c0<=c1, c1<=c2, c2<=captured; compute Gx, Gy.
  - s6: |Gx|+|Gy|, scale, threshold.
  - s7: write (PIXEL only); advance x/y.
- Out-of-image taps (row -1, row HEIGHT, column WIDTH):
  - Captured as 0.
  - `read_addr` holds its previous value for those cycles.
- Arithmetic:
  - Gx = (p02+2p12+p22) − (p00+2p10+p20).
  - Gy = (p20+2p21+p22) − (p00+2p01+p02).
  - Both are 13-bit signed, range ±4092.
  - Sum = |Gx|+|Gy|, 13-bit unsigned, max 8184.
  - mag = sum[12:3], no saturation needed.
  - edge = (mag >= THRESHOLD).
- Border pixels (x==0, x==WIDTH-1, y==0, y==HEIGHT-1) are written with mag=0 and edge=0. They still receive a write.
- Scan order:
  - x increments after each PIXEL slot.
  - At x==WIDTH-1: x<=0, y<=y+1, next slot is PRIME.
  - At (WIDTH-1, HEIGHT-1): go to FINISH.
- `start` in any state:
  - Aborts the current frame.
  - Resets x, y, window and slot counter.
  - Enters PRIME for row 0 on the next cycle.
- `start` simultaneous with FINISH: `start` wins, and `done` is suppressed.

## Timing
- Reset values:
  - `done`=0, `write_enable`=0.
  - `read_addr`=0, `write_addr`=0, `write_data`=0.
  - state IDLE, x=y=0, window=0.
- Slot length is fixed at 8 cycles, with no stalls; memory is always ready.
- Frame latency from `start` to `done` = HEIGHT·(WIDTH+1)·8 + 2 cycles. For defaults: 2,461,442.
- `write_enable` is high only in s7 of PIXEL slots: exactly WIDTH·HEIGHT strobes per frame.
- `write_addr` and `write_data` are valid in the same cycle as `write_enable` and hold until the next write.
- `done` is high for exactly one cycle, the cycle after the final s7.
- Reset asserted mid-frame:
  - Immediate return to IDLE, all outputs at reset values.
  - No further writes.
  - No `done`.

## Test plan
- Uniform frame (all luma 300), WIDTH=8, HEIGHT=4:
  - 32 writes, all mag=0, edge=0.
  - `done` at cycle 4·9·8+2 = 290.
- Vertical step (x<4 luma 0, x≥4 luma 1000), 8×4, THRESHOLD=128:
  - Interior pixels at x=3 and x=4: Gx=4000, mag=500, edge=1.
  - All other interior pixels: mag=0.
- Horizontal step (rows 0–1 luma 0, rows 2–3 luma 1023), 8×4:
  - Interior pixels at y=1 and y=2: mag=511, edge=1.
  - Border pixels: mag=0.
- Single hot pixel 1023 at (3,2), 8×4:
  - (2,1): mag=255.
  - (3,1): mag=255.
  - (3,2): mag=0.
  - `write_data[19:0]` is always 20'h80200.
- Reset low at cycle 100 of a frame:
  - All outputs are 0 the same cycle.
  - No `write_enable` and no `done` afterwards.
  - A new `start` produces a full correct frame.
- `start` re-pulsed mid-frame at cycle 150:
  - Writes restart at address 0.
  - Exactly one `done`, 290 cycles after the second `start`.
